// File: rtl/fp_mul_pkg.sv
// Shared types and helper functions for the parameterised floating-point multiplier.
// Helpers return 128-bit vectors; callers keep the low 1+EXP_W+MAN_W bits.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set.
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = '0;
    for (int i = man_w; i < man_w + exp_w; i++) r[i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

  // Largest finite magnitude: exponent all-ones minus one, fraction all ones.
  function automatic logic [127:0] maxfin(input int exp_w, input int man_w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < man_w; i++) r[i] = 1'b1;
    for (int i = man_w + 1; i < man_w + exp_w; i++) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/multiplier_fp_param_classify.sv
// Combinational unpack of one operand into sign, exponent, significand and class.
// Subnormal encodings are treated as zero (flush-to-zero on input).
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig,
  output fp_class_t            cls
);

  logic [MAN_W-1:0] frac;

  always_comb begin
    sign = op[EXP_W+MAN_W];
    exp  = op[EXP_W+MAN_W-1 -: EXP_W];
    frac = op[MAN_W-1:0];
    sig  = {1'b1, frac};
    if (exp == '0)
      cls = ZERO;
    else if (exp == '1)
      cls = (frac != '0) ? NAN : INF;
    else
      cls = NORMAL;
  end

endmodule

// File: rtl/multiplier_fp_param.sv
// Multi-cycle parameterised floating-point multiplier with start/ready handshake,
// RNE or truncate rounding, saturation on overflow and flush-to-zero on underflow.
module multiplier_fp_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rnd_mode,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 busy,
  output logic                 ready,
  output logic [EXP_W+MAN_W:0] Y,
  output logic                 invalid,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam int BIAS_I = bias(EXP_W);
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] BIAS_S   = BIAS_I[EW-1:0];
  localparam logic signed [EW-1:0] EXP_MAX  = EMAX_I[EW-1:0];
  localparam logic [127:0]         QNAN_ALL = qnan(EXP_W, MAN_W);
  localparam logic [127:0]         MAXF_ALL = maxfin(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN     = QNAN_ALL[W-1:0];
  localparam logic [W-2:0]         MAXF_MAG = MAXF_ALL[W-2:0];
  localparam logic [W-2:0]         INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_t state;

  logic [W-1:0]         a_r, b_r;
  logic                 rnd_r;
  logic                 res_sign;
  logic signed [EW-1:0] exp_r;
  logic [PW-1:0]        prod_r;
  logic [MAN_W-1:0]     frac_r;
  logic                 g_r, s_r;
  logic [W-1:0]         y_p;
  logic                 inv_p, ovf_p, unf_p, inx_p;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   sig_a, sig_b;
  fp_class_t        cls_a, cls_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op(a_r), .sign(sign_a), .exp(exp_a), .sig(sig_a), .cls(cls_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op(b_r), .sign(sign_b), .exp(exp_b), .sig(sig_b), .cls(cls_b)
  );

  logic                 sign_xy;
  logic signed [EW-1:0] exp_sum;
  logic [PW-1:0]        product;
  logic                 spec_hit, spec_inv;
  logic [W-1:0]         spec_y;

  // Special-case resolution in priority order: NaN, inf*0, inf, zero.
  always_comb begin
    sign_xy  = sign_a ^ sign_b;
    exp_sum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    product  = PW'(sig_a) * PW'(sig_b);
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_y   = '0;
    if (cls_a == NAN || cls_b == NAN) begin
      spec_y   = QNAN;
      spec_inv = 1'b1;
    end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
      spec_y   = QNAN;
      spec_inv = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      spec_y = {sign_xy, INF_MAG};
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      spec_y = {sign_xy, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [PW-1:0] norm_prod;

  assign norm_prod = prod_r[PW-1] ? prod_r : (prod_r << 1);

  logic                 rnd_inc;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] exp_fin;
  logic                 ovf_det, unf_det;

  // Rounding increment; a carry out of the fraction leaves it zero and bumps the exponent.
  always_comb begin
    rnd_inc  = !rnd_r && g_r && (s_r || frac_r[0]);
    frac_sum = {1'b0, frac_r} + {{MAN_W{1'b0}}, rnd_inc};
    exp_fin  = exp_r + $signed({{(EW-1){1'b0}}, frac_sum[MAN_W]});
    ovf_det  = !exp_fin[EW-1] && (exp_fin >= EXP_MAX);
    unf_det  = exp_fin[EW-1] || (exp_fin == '0);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b0;
      Y         <= '0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      rnd_r     <= 1'b0;
      res_sign  <= 1'b0;
      exp_r     <= '0;
      prod_r    <= '0;
      frac_r    <= '0;
      g_r       <= 1'b0;
      s_r       <= 1'b0;
      y_p       <= '0;
      inv_p     <= 1'b0;
      ovf_p     <= 1'b0;
      unf_p     <= 1'b0;
      inx_p     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r       <= A;
            b_r       <= B;
            rnd_r     <= rnd_mode;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          res_sign <= sign_xy;
          inv_p    <= 1'b0;
          ovf_p    <= 1'b0;
          unf_p    <= 1'b0;
          inx_p    <= 1'b0;
          if (spec_hit) begin
            y_p   <= spec_y;
            inv_p <= spec_inv;
            state <= DONE;
          end else begin
            exp_r  <= exp_sum;
            prod_r <= product;
            state  <= NORM;
          end
        end
        NORM: begin
          frac_r <= norm_prod[PW-2 -: MAN_W];
          g_r    <= norm_prod[MAN_W];
          s_r    <= |norm_prod[MAN_W-1:0];
          if (prod_r[PW-1])
            exp_r <= exp_r + EW'(1);
          state <= ROUND;
        end
        ROUND: begin
          if (ovf_det) begin
            y_p   <= rnd_r ? {res_sign, MAXF_MAG} : {res_sign, INF_MAG};
            ovf_p <= 1'b1;
            inx_p <= 1'b1;
          end else if (unf_det) begin
            y_p   <= {res_sign, {(W-1){1'b0}}};
            unf_p <= 1'b1;
            inx_p <= 1'b1;
          end else begin
            y_p   <= {res_sign, exp_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
            inx_p <= g_r | s_r;
          end
          state <= DONE;
        end
        DONE: begin
          Y         <= y_p;
          invalid   <= inv_p;
          overflow  <= ovf_p;
          underflow <= unf_p;
          inexact   <= inx_p;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_fp_param.sv
// Directed-vector bench for the single-precision configuration of multiplier_fp_param.
// Flags are compared as {invalid, overflow, underflow, inexact}.
module tb_multiplier_fp_param;

  logic        clk = 1'b0;
  logic        reset, start, rnd_mode;
  logic [31:0] A, B, Y;
  logic        busy, ready, invalid, overflow, underflow, inexact;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  assign flags = {invalid, overflow, underflow, inexact};

  multiplier_fp_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .rnd_mode(rnd_mode),
    .A(A), .B(B), .busy(busy), .ready(ready), .Y(Y),
    .invalid(invalid), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Launches one operation from just after a clock edge and checks the whole transaction.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic rnd, input logic [31:0] exp_y,
                               input logic [3:0] exp_flags, input int exp_lat);
    int edges;
    bit got;
    A        = a;
    B        = b;
    rnd_mode = rnd;
    start    = 1'b1;
    edges    = 0;
    got      = 0;
    while (edges < 20 && !got) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        checkOutput({tag, "_flagclr"}, 64'(flags), 64'd0);
      end
      if (ready) got = 1;
    end
    checkOutput({tag, "_ready"}, 64'(ready), 64'd1);
    checkOutput({tag, "_lat"}, 64'(edges - 1), 64'(exp_lat));
    checkOutput({tag, "_y"}, 64'(Y), 64'(exp_y));
    checkOutput({tag, "_flags"}, 64'(flags), 64'(exp_flags));
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen_ready;
    reset    = 1'b1;
    start    = 1'b0;
    rnd_mode = 1'b0;
    A        = '0;
    B        = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_y", 64'(Y), 64'd0);
    checkOutput("rst_flags", 64'(flags), 64'd0);

    // Consecutive calls start during the ready cycle, exercising back-to-back acceptance.
    applyStimulus("mul_1p5x2",   32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4);
    applyStimulus("mul_m2x3",    32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'b0000, 4);
    applyStimulus("negzero",     32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000, 2);
    applyStimulus("infxzero",    32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    applyStimulus("nanx1",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    applyStimulus("ninfx2",      32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000, 2);
    applyStimulus("ovf_rne",     32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101, 4);
    applyStimulus("ovf_trunc",   32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101, 4);
    applyStimulus("sticky_rne",  32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'b0001, 4);
    applyStimulus("unf",         32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011, 4);
    applyStimulus("lead_msb",    32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 4'b0000, 4);
    applyStimulus("rnd_up_rne",  32'h3FC00001, 32'h3F800001, 1'b0, 32'h3FC00003, 4'b0001, 4);
    applyStimulus("rnd_trunc",   32'h3FC00001, 32'h3F800001, 1'b1, 32'h3FC00002, 4'b0001, 4);

    @(posedge clk);
    #1;
    checkOutput("ready_pulse", 64'(ready), 64'd0);
    checkOutput("y_hold", 64'(Y), 64'h3FC00002);

    // Abort an operation while it sits in NORM.
    A        = 32'h3FC00000;
    B        = 32'h40000000;
    rnd_mode = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_y", 64'(Y), 64'd0);
    checkOutput("abort_flags", 64'(flags), 64'd0);
    seen_ready = 0;
    repeat (6) begin
      if (ready) seen_ready = 1;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_noready", 64'(seen_ready), 64'd0);
    applyStimulus("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_fp_param.md
Name: multiplier_fp_param

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point multiplier with a start/ready/busy handshake. It is the next generation of the single-precision multiplier and sits in the same datapath (sum-of-squared-error accumulation).
- Adds generic exponent/mantissa widths, round-to-nearest-even with guard/sticky bits, and a selectable truncate mode.
- Adds correct zero/NaN/infinity semantics, overflow/underflow saturation, and exception flags.
- Subnormals are flushed to zero on input and output.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
rnd_mode  in  1  0 = round-to-nearest-even, 1 = truncate (toward zero); captured with operands
A  in  W  operand A, captured when start accepted
B  in  W  operand B, captured when start accepted
busy  out  1  high while an operation is in flight (state != IDLE)
ready  out  1  one-cycle pulse: Y and flags valid
Y  out  W  result; holds until next ready
invalid  out  1  NaN operand or inf*0; valid with ready, held after
overflow  out  1  result exponent above max; valid with ready
underflow  out  1  result below min normal, flushed to zero
inexact  out  1  nonzero bits discarded by rounding/overflow/underflow

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything, including mid-operation.
  - Reset values: state=IDLE, busy=0, ready=0, Y=0, all flags=0.
  - An aborted operation never produces a ready pulse.
- FSM states: IDLE -> CHECK -> {DONE (special) | NORM -> ROUND -> DONE} -> IDLE.
- IDLE:
  - On start=1, register A, B and rnd_mode.
  - Set busy=1 on the same edge and go to CHECK.
  - start is ignored in all other states.
- CHECK:
  - Classify each operand: exp==0 -> zero (fraction ignored, FTZ); exp all-ones with fraction!=0 -> NaN; exp all-ones with fraction==0 -> inf; otherwise normal.
  - Result sign = sA^sB for every non-NaN result.
  - Special cases, in priority order, go straight to DONE:
    - Any NaN -> canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
    - inf*zero -> canonical qNaN, invalid=1.
    - inf*(inf or normal) -> signed inf.
    - zero*(zero or normal) -> signed zero.
  - Normal*normal:
    - Compute exp_sum = eA+eB-BIAS, where BIAS = 2^(EXP_W-1)-1, in signed EXP_W+2 bits.
    - Compute the product of the two (MAN_W+1)-bit significands, 2*MAN_W+2 bits wide.
    - Go to NORM.
- NORM:
  - If product MSB=1, exp+1 and the leading bit is MSB; otherwise the leading bit is MSB-1.
  - Extract MAN_W fraction bits, guard bit G, and sticky S (OR of all lower bits).
- ROUND:
  - RNE: increment when G & (S | lsb). Truncate: never increment.
  - A fraction carry-out sets the fraction to 0 and exp+1, in the same cycle.
  - Overflow (exp >= 2^EXP_W-1): RNE -> signed inf; truncate -> signed max finite. Set overflow=1 and inexact=1.
  - Underflow (exp <= 0): signed zero, underflow=1, inexact=1.
  - Otherwise inexact = G|S.
- DONE: register Y and flags, ready=1 and busy=0 on the same edge, return to IDLE.
- Latency from the edge that samples start to the edge that asserts ready: 4 edges for normal operands, 2 edges for special cases.
- Back-to-back: a start asserted during the ready cycle is accepted (the FSM is in IDLE).
- Flags describe only the most recent operation; all flags are cleared when a new start is accepted.

Decomposition:
- Package fp_mul_pkg holds:
  - state enum (IDLE, CHECK, NORM, ROUND, DONE);
  - class enum (ZERO, NORMAL, INF, NAN);
  - functions bias(EXP_W), qnan(EXP_W,MAN_W), maxfin(EXP_W,MAN_W).
- One natural sub-module: fp_classify. It is a combinational unpack/classify of one operand into sign, exp, significand and class, instantiated twice.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE -> Y=0x40400000, ready 4 edges after start, all flags 0.
- 0xC0000000 * 0x40400000 -> Y=0xC0C00000; then 0x80000000 * 0x3F800000 -> Y=0x80000000 at 2-edge latency.
- 0x7F800000 * 0x00000000 -> Y=0x7FC00000, invalid=1; 0x7F800001 * 0x3F800000 -> 0x7FC00000, invalid=1.
- 0x7F000000 * 0x7F000000: RNE -> 0x7F800000 with overflow=1, inexact=1; truncate -> 0x7F7FFFFF with overflow=1.
- 0x3F800001 * 0x3F800001: RNE -> 0x3F800002, inexact=1. 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- Assert reset for one cycle while state=NORM -> busy=0, Y=0, no ready pulse. Next start 0x3F800000*0x3F800000 -> 0x3F800000.
